fpu_addsub_pipe: RTL and testbench
==================================

FPU_ADDSUB_PIPE -- requirements
Module: fpu_addsub_pipe

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have in_valid, input, 1, operand request valid.
REQ-004 SHALL have in_ready, output, 1, request accepted when in_valid && in_ready at a clk edge.
REQ-005 SHALL have op, input, 1, 0 = x1 + x2, 1 = x1 - x2.
REQ-006 SHALL have x1 and x2, input, 32 each, IEEE-754 single operands.
REQ-007 SHALL have tag, input, 4, opaque request id returned with the result.
REQ-008 SHALL have out_valid, output, 1, result valid.
REQ-009 SHALL have out_ready, input, 1, result consumed when out_valid && out_ready at a clk edge.
REQ-010 SHALL have y, output, 32; out_ovf, output, 1; out_tag, output, 4: result, overflow, and returned tag.
REQ-011 SHALL have clr_flags, input, 1, clears the sticky flags.
REQ-012 SHALL have ovf_sticky, output, 1; nan_sticky, output, 1: accumulated exception flags.
REQ-013 SHALL have inflight, output, 2, number of valid pipeline stages (0..2).

Function
REQ-014 SHALL be a two-stage pipeline: S1 = operand register {op, x1, x2, tag}; S2 = result register {y, ovf, tag}.
REQ-015 SHALL compute the S2 input combinationally from S1 through the subtractor with operands (x1, x2 with bit 31 inverted when op = 0, x2 unchanged when op = 1).
REQ-016 SHALL use the stall enables s2_en = ~s2_valid | out_ready, s1_en = ~s1_valid | s2_en, and in_ready = s1_en; no combinational path from in_valid to in_ready.
REQ-017 SHALL load S1 when s1_en; s1_valid then takes in_valid. S1 SHALL hold its contents when s1_en is low.
REQ-018 SHALL load S2 when s2_en; s2_valid then takes s1_valid. S2 SHALL hold y/out_ovf/out_tag stable while out_valid && !out_ready.
REQ-019 SHALL present a request accepted at edge k as out_valid after edge k+1 (latency 2 edges) when there is no backpressure.
REQ-020 SHALL sustain one result per cycle under continuous in_valid and out_ready.
REQ-021 SHALL drive out_valid = s2_valid, with y, out_ovf and out_tag taken directly from S2.
REQ-022 SHALL drive inflight = s1_valid + s2_valid.
REQ-023 SHALL, with both stages full and out_ready low, hold in_ready low and keep all state unchanged.
REQ-024 SHALL set ovf_sticky on an output handshake carrying out_ovf = 1.
REQ-025 SHALL set nan_sticky on an output handshake whose y has exponent 0xFF and a nonzero mantissa.
REQ-026 SHALL clear both sticky flags on clr_flags; when a set and clr_flags fall on the same edge, the set SHALL win.
REQ-027 SHALL treat out_ready while out_valid is low as don't-care.
REQ-028 SHALL keep x1, x2 and op as don't-care while in_valid is low; S1 MAY capture them but s1_valid = 0.

Reset
REQ-029 SHALL, on rstn low, asynchronously clear s1_valid, s2_valid, ovf_sticky and nan_sticky, and zero y, out_ovf and out_tag.
REQ-030 SHALL drive in_ready = 1, out_valid = 0 and inflight = 0 during and after reset.
REQ-031 SHALL discard in-flight requests on reset mid-operation; they SHALL NOT emerge after rstn rises.

Structure
REQ-032 SHALL instantiate the existing fsub block as its single sub-module, located between S1 and S2.
REQ-033 SHALL place the widths FP_W = 32 and TAG_W = 4 and the constants OP_ADD = 0 and OP_SUB = 1 in the shared FPU package.

Verification
REQ-034 SHALL cover: op = 1, x1 = x2 = 0x3F800000, tag = 5 -> y = 0x00000000, out_tag = 5, out_valid 2 edges after accept.
REQ-035 SHALL cover: op = 0, x1 = x2 = 0x3F800000 -> y = 0x40000000, out_ovf = 0.
REQ-036 SHALL cover: op = 0, x1 = x2 = 0x7F7FFFFF -> out_ovf = 1; ovf_sticky = 1 after the handshake; clr_flags -> ovf_sticky = 0.
REQ-037 SHALL cover: op = 1, x1 = x2 = 0x7F800000 -> y = 0xFFC00000, nan_sticky = 1.
REQ-038 SHALL cover: 4 back-to-back requests with out_ready low for 5 cycles -> in_ready falls after 2 accepts, inflight = 2, y stable; on release, results emerge in tag order.
REQ-039 SHALL cover: rstn pulsed low with inflight = 2 -> out_valid = 0, inflight = 0, sticky flags = 0, and no stale result afterwards.

Source files
------------

// File: rtl/fpu_addsub_pipe_pkg.sv
// rtl/fpu_addsub_pipe_pkg.sv - shared FPU widths, opcodes and helpers
package fpu_addsub_pipe_pkg;

    localparam int FP_W  = 32;
    localparam int TAG_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [FP_W-1:0] QNAN = 32'hFFC0_0000;

    typedef struct packed {
        logic             op;
        logic [FP_W-1:0]  x1;
        logic [FP_W-1:0]  x2;
        logic [TAG_W-1:0] tag;
    } req_t;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

endpackage

// File: rtl/fsub.sv
// rtl/fsub.sv - combinational IEEE-754 single a - b, round-to-nearest-even
module fsub
    import fpu_addsub_pipe_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] y,
    output logic            ovf
);

    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
    logic        sgn_big, sgn_sml, eff_sub, res_sgn, stk, up;
    logic [7:0]  ea, eb, ea_f, eb_f, e_big, e_sml, d;
    logic [23:0] ma, mb, m_big, m_sml;
    logic [26:0] sm_ext, al, mask, n;
    logic [27:0] sum;
    logic [4:0]  lz, sh;
    logic [9:0]  e, e_fin;
    logic [24:0] m_r;
    logic [22:0] frac;

    always_comb begin
        sa    = a[31];
        sb    = ~b[31];
        ea    = a[30:23];
        eb    = b[30:23];
        a_nan = (&ea) & (|a[22:0]);
        b_nan = (&eb) & (|b[22:0]);
        a_inf = (&ea) & ~(|a[22:0]);
        b_inf = (&eb) & ~(|b[22:0]);
        // denormals share exponent 1 with a zero hidden bit
        ma    = {|ea, a[22:0]};
        mb    = {|eb, b[22:0]};
        ea_f  = (ea == 8'd0) ? 8'd1 : ea;
        eb_f  = (eb == 8'd0) ? 8'd1 : eb;

        swap    = b[30:0] > a[30:0];
        e_big   = swap ? eb_f : ea_f;
        e_sml   = swap ? ea_f : eb_f;
        m_big   = swap ? mb : ma;
        m_sml   = swap ? ma : mb;
        sgn_big = swap ? sb : sa;
        sgn_sml = swap ? sa : sb;
        d       = e_big - e_sml;

        sm_ext = {m_sml, 3'b000};
        mask   = '0;
        if (d >= 8'd27) begin
            al  = '0;
            stk = |sm_ext;
        end else begin
            al   = sm_ext >> d;
            mask = (27'd1 << d) - 27'd1;
            stk  = |(sm_ext & mask);
        end
        al[0] = al[0] | stk;

        eff_sub = sgn_big ^ sgn_sml;
        sum = eff_sub ? ({1'b0, m_big, 3'b000} - {1'b0, al})
                      : ({1'b0, m_big, 3'b000} + {1'b0, al});
        // exact cancellation yields +0; like-signed zeros keep their sign
        res_sgn = (sum == 28'd0) ? (sgn_big & ~eff_sub) : sgn_big;

        e  = {2'b00, e_big};
        lz = '0;
        sh = '0;
        if (sum[27]) begin
            n = sum[27:1] | {26'd0, sum[0]};
            e = e + 10'd1;
        end else begin
            lz = lzc27(sum[26:0]);
            if ({5'd0, lz} < e - 10'd1) sh = lz;
            else                        sh = 5'(e - 10'd1);
            n = sum[26:0] << sh;
            e = e - {5'd0, sh};
        end

        up  = n[2] & (n[1] | n[0] | n[3]);
        m_r = {1'b0, n[26:3]} + {24'd0, up};
        if (m_r[24]) begin
            frac  = m_r[23:1];
            e_fin = e + 10'd1;
        end else begin
            frac  = m_r[22:0];
            e_fin = m_r[23] ? e : 10'd0;
        end

        ovf = 1'b0;
        if (e_fin >= 10'd255) begin
            y   = {res_sgn, 8'hFF, 23'd0};
            ovf = 1'b1;
        end else begin
            y = {res_sgn, e_fin[7:0], frac};
        end

        if (a_nan | b_nan | (a_inf & b_inf & (sa ^ sb))) begin
            y   = QNAN;
            ovf = 1'b0;
        end else if (a_inf) begin
            y   = {sa, 8'hFF, 23'd0};
            ovf = 1'b0;
        end else if (b_inf) begin
            y   = {sb, 8'hFF, 23'd0};
            ovf = 1'b0;
        end
    end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// rtl/fpu_addsub_pipe.sv - two-stage valid/ready float add/sub pipeline
module fpu_addsub_pipe
    import fpu_addsub_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [FP_W-1:0]  x1,
    input  logic [FP_W-1:0]  x2,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  y,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    input  logic             clr_flags,
    output logic             ovf_sticky,
    output logic             nan_sticky,
    output logic [1:0]       inflight
);

    logic            s1_valid, s2_valid, s1_en, s2_en;
    req_t            s1;
    logic [FP_W-1:0] sub_b, sub_y;
    logic            sub_ovf, out_hs, y_nan;

    // enables depend only on registered state, never on in_valid
    assign s2_en    = ~s2_valid | out_ready;
    assign s1_en    = ~s1_valid | s2_en;
    assign in_ready = s1_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            s1       <= {op, x1, x2, tag};
        end
    end

    assign sub_b = (s1.op == OP_ADD) ? {~s1.x2[FP_W-1], s1.x2[FP_W-2:0]} : s1.x2;

    fsub u_fsub (
        .a   (s1.x1),
        .b   (sub_b),
        .y   (sub_y),
        .ovf (sub_ovf)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid <= 1'b0;
            y        <= '0;
            out_ovf  <= 1'b0;
            out_tag  <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y       <= sub_y;
                out_ovf <= sub_ovf;
                out_tag <= s1.tag;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_hs    = s2_valid & out_ready;
    assign y_nan     = (&y[30:23]) & (|y[22:0]);
    assign inflight  = {1'b0, s1_valid} + {1'b0, s2_valid};

    // a set on the same edge as clr_flags wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf_sticky <= 1'b0;
            nan_sticky <= 1'b0;
        end else begin
            ovf_sticky <= (ovf_sticky & ~clr_flags) | (out_hs & out_ovf);
            nan_sticky <= (nan_sticky & ~clr_flags) | (out_hs & y_nan);
        end
    end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// tb/tb_fpu_addsub_pipe.sv - scoreboard bench for fpu_addsub_pipe
module tb_fpu_addsub_pipe;

    logic        clk, rstn, in_valid, in_ready, op, out_valid, out_ready;
    logic [31:0] x1, x2, y;
    logic [3:0]  tag, out_tag;
    logic        out_ovf, clr_flags, ovf_sticky, nan_sticky;
    logic [1:0]  inflight;

    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [31:0] y;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    localparam int NV = 15;
    vec_t vt[NV];
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   sent    = 0;
    int   cyc     = 0;
    int   t0, t1;

    fpu_addsub_pipe dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .x1         (x1),
        .x2         (x2),
        .tag        (tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .out_ovf    (out_ovf),
        .out_tag    (out_tag),
        .clr_flags  (clr_flags),
        .ovf_sticky (ovf_sticky),
        .nan_sticky (nan_sticky),
        .inflight   (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [3:0] t);
        int n;
        n        = 0;
        op       = vt[idx].op;
        x1       = vt[idx].a;
        x2       = vt[idx].b;
        tag      = t;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready || n >= 200) break;
            n++;
        end
        if (!in_ready) chk("send_ready", {31'd0, in_ready}, 32'd1);
        else exp_q.push_back({vt[idx].y, vt[idx].ovf, t});
        tick();
        in_valid = 1'b0;
        sent++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("y", y, mon_e.y);
                chk("ovf", {31'd0, out_ovf}, {31'd0, mon_e.ovf});
                chk("tag", {28'd0, out_tag}, {28'd0, mon_e.tag});
            end
        end
    end

    initial begin
        vt[0]  = {1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0};
        vt[1]  = {1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0};
        vt[2]  = {1'b0, 32'h3FC00000, 32'h40100000, 32'h40700000, 1'b0};
        vt[3]  = {1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0};
        vt[4]  = {1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0};
        vt[5]  = {1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0};
        vt[6]  = {1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0};
        vt[7]  = {1'b1, 32'h3F800001, 32'h3F800000, 32'h34000000, 1'b0};
        vt[8]  = {1'b0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0};
        vt[9]  = {1'b1, 32'h00800000, 32'h00000001, 32'h007FFFFF, 1'b0};
        vt[10] = {1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1};
        vt[11] = {1'b0, 32'h7F7FFFFF, 32'h73000000, 32'h7F800000, 1'b1};
        vt[12] = {1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0};
        vt[13] = {1'b1, 32'h7F800000, 32'h7F800000, 32'hFFC00000, 1'b0};
        vt[14] = {1'b1, 32'h40000000, 32'h3FC00000, 32'h3F000000, 1'b0};

        rstn = 1'b0; in_valid = 1'b0; op = 1'b0; x1 = '0; x2 = '0; tag = '0;
        out_ready = 1'b0; clr_flags = 1'b0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_inflight", {30'd0, inflight}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_flags", {30'd0, ovf_sticky, nan_sticky}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // latency: 1 - 1 with tag 5 appears two edges after accept
        out_ready = 1'b1;
        send(1, 4'd5);
        chk("lat_k_valid", {31'd0, out_valid}, 32'd0);
        chk("lat_k_inflight", {30'd0, inflight}, 32'd1);
        tick();
        chk("lat_k1_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // full table streamed back to back
        t0 = cyc;
        for (int i = 0; i < NV; i++) send(i, 4'(i));
        t1 = cyc;
        chk("throughput", t1 - t0, NV);
        drain();
        chk("ovf_sticky_set", {31'd0, ovf_sticky}, 32'd1);
        chk("nan_sticky_set", {31'd0, nan_sticky}, 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("flags_cleared", {30'd0, ovf_sticky, nan_sticky}, 32'd0);

        // clr_flags coinciding with an overflow handshake: set wins
        out_ready = 1'b0;
        send(10, 4'd3);
        tick();
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        clr_flags = 1'b1;
        out_ready = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("set_wins", {31'd0, ovf_sticky}, 32'd1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("clr_ovf", {31'd0, ovf_sticky}, 32'd0);
        drain();

        // backpressure: four requests, out_ready low for five cycles
        out_ready = 1'b0;
        sent = 0;
        fork
            for (int i = 0; i < 4; i++) send(i, 4'(8 + i));
            begin
                tick();
                tick();
                chk("bp_inflight_a", {30'd0, inflight}, 32'd2);
                chk("bp_y_a", y, 32'h40000000);
                tick();
                tick();
                tick();
                chk("bp_accepts", sent, 32'd2);
                chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                chk("bp_inflight_b", {30'd0, inflight}, 32'd2);
                chk("bp_y_b", y, 32'h40000000);
                chk("bp_tag", {28'd0, out_tag}, 32'd8);
                out_ready = 1'b1;
            end
        join
        drain();

        // reset with two requests in flight
        send(10, 4'd1);
        drain();
        chk("pre_rst_ovf", {31'd0, ovf_sticky}, 32'd1);
        out_ready = 1'b0;
        send(0, 4'd6);
        send(2, 4'd7);
        chk("pre_rst_inflight", {30'd0, inflight}, 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_inflight", {30'd0, inflight}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_flags", {30'd0, ovf_sticky, nan_sticky}, 32'd0);
        exp_q.delete();
        tick();
        rstn = 1'b1;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("no_stale_valid", {31'd0, out_valid}, 32'd0);
        chk("no_stale_inflight", {30'd0, inflight}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
